lpc_packer: RTL and testbench
=============================

Name: lpc_packer

Overview:
Downstream stage of the `lpc` decoder in the sniffer. It captures each decoded LPC transaction on the decoder's clock-enable strobe and buffers it in a small record FIFO. It then serialises each record into a framed byte stream with a valid/ready handshake toward the UART transmitter. Overflow is never silent: dropped records are counted and flagged in the stream.

Parameters:
DEPTH, 4, number of buffered transaction records (power of 2, ≥2)
SYNC_BYTE, 8'hA5, first byte of every frame

Ports:
lpc_clock  input  1  sole clock (LPC clock domain)
lpc_reset  input  1  synchronous, active-high reset
in_valid  input  1  one-cycle strobe, driven by decoder out_clock_enable
in_cyctype_dir  input  4  cycle type/direction from decoder
in_addr  input  32  transaction address
in_data  input  32  transaction data, byte 0 in [7:0]
in_data_size  input  3  number of valid data bytes, 0..4
out_byte  output  8  stream byte
out_valid  output  1  out_byte valid
out_ready  input  1  sink accepts byte when out_valid & out_ready
drop_count  output  8  saturating count of dropped records
overflow  output  1  sticky: at least one record dropped since reset

Behaviour:
- Reset (synchronous, lpc_reset=1 at an edge): FIFO empty, FSM=IDLE, out_valid=0, out_byte=0, drop_count=0, overflow=0, pending-loss flag=0. Reset mid-frame abandons the frame immediately; no partial bytes follow.
- Push: on in_valid, store {lost, ct_dir, addr, data, size} (72 bits). lost = current pending-loss flag, which then clears.
- Full: if the FIFO is full at the edge sampling in_valid, the record is dropped. This uses pre-pop occupancy, so push while full with a same-cycle pop still drops. On drop: drop_count += 1 (saturates at 255), overflow=1, pending-loss=1.
- in_data_size > 4 is clamped to 4 on push.
- Frame format, in order:
  - SYNC_BYTE
  - header = {ct_dir[3:0], lost, size[2:0]}
  - addr bytes, MSB first (4 bytes)
  - `size` data bytes, LSB first
  - checksum = XOR of header, addr and data bytes (SYNC excluded)
  - Length is 7..11 bytes.
- FSM states: IDLE, SYNC, HEADER, ADDR, DATA, CSUM.
  - IDLE: if FIFO non-empty, pop into the record register and go to SYNC. out_valid=0.
  - SYNC → HEADER → ADDR → DATA → CSUM → IDLE. Each state advances only on out_valid & out_ready.
  - ADDR uses a 2-bit byte counter, 3 down to 0.
  - DATA uses a byte counter 0..size-1. When size=0, HEADER-then-ADDR goes straight to CSUM.
- Output timing:
  - out_valid=1 in every state except IDLE.
  - out_byte is registered and held stable while out_valid & !out_ready.
  - After CSUM is accepted, the FSM returns to IDLE for exactly one cycle before the next frame.
- Latency: with an empty FIFO and out_ready=1, in_valid sampled at edge N gives SYNC on out_byte after edge N+2.
- Checksum is accumulated in a register as bytes are loaded. It is cleared on entering SYNC.

Decomposition:
- Shared include lpc_defs.vh holds:
  - CT_DIR field encodings
  - SYNC_BYTE default
  - record field widths and bit offsets (lost, ct_dir, addr, data, size)
  - FSM state encodings
  - MAX_DATA_BYTES=4
- One sub-module, lpc_fifo: synchronous FIFO with parameters WIDTH and DEPTH, push/pop, full/empty, one-cycle read via registered pop. lpc_packer holds the framing FSM, checksum and drop logic.

Test Plan:
- 32-bit mem write: ct_dir=4'b0110, addr=0x12347FE0, data=0x000069CD, size=4, out_ready=1 -> bytes A5 64 12 34 7F E0 CD 69 00 00 79; first byte after edge N+2.
- 16-bit mem read: ct_dir=4'b0100, addr=0x12347FE4, data=0x69CE, size=2 -> A5 42 12 34 7F E4 CE 69 58. Sent back-to-back after the previous test with one IDLE cycle between frames.
- Backpressure: toggle out_ready randomly during the 16-bit read -> identical byte sequence; out_byte never changes while out_valid & !out_ready.
- Overflow: DEPTH=4, out_ready=0, push 6 records -> drop_count=2, overflow=1. Drain one frame, then push a 7th (size=0, ct_dir=0, addr=0) -> its frame is A5 08 00 00 00 00 08.
- Size clamp/zero: size=7 emits 4 data bytes; size=0 emits a 7-byte frame.
- Reset mid-frame: assert lpc_reset after the 3rd byte is accepted -> next cycle out_valid=0, FIFO empty, drop_count=0, no further bytes.

Source files
------------

// File: rtl/lpc_packer_pkg.sv
// Shared definitions for the LPC transaction packer: field encodings,
// record layout and framing FSM states.
package lpc_packer_pkg;

  localparam logic [3:0] CT_IO_READ   = 4'b0000;
  localparam logic [3:0] CT_IO_WRITE  = 4'b0010;
  localparam logic [3:0] CT_MEM_READ  = 4'b0100;
  localparam logic [3:0] CT_MEM_WRITE = 4'b0110;
  localparam logic [3:0] CT_DMA_READ  = 4'b1000;
  localparam logic [3:0] CT_DMA_WRITE = 4'b1010;

  localparam logic [7:0] SYNC_BYTE_DEFAULT = 8'hA5;
  localparam int         MAX_DATA_BYTES    = 4;

  // Record layout, LSB first: size, data, addr, ct_dir, lost
  localparam int REC_SIZE_W   = 3;
  localparam int REC_DATA_W   = 32;
  localparam int REC_ADDR_W   = 32;
  localparam int REC_CT_W     = 4;
  localparam int REC_SIZE_LSB = 0;
  localparam int REC_DATA_LSB = REC_SIZE_LSB + REC_SIZE_W;
  localparam int REC_ADDR_LSB = REC_DATA_LSB + REC_DATA_W;
  localparam int REC_CT_LSB   = REC_ADDR_LSB + REC_ADDR_W;
  localparam int REC_LOST_BIT = REC_CT_LSB + REC_CT_W;
  localparam int REC_W        = REC_LOST_BIT + 1;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_SYNC   = 3'd1,
    ST_HEADER = 3'd2,
    ST_ADDR   = 3'd3,
    ST_DATA   = 3'd4,
    ST_CSUM   = 3'd5
  } pkt_state_e;

endpackage

// File: rtl/lpc_fifo.sv
// Synchronous record FIFO; rd_data is a register loaded on pop and held
// until the next pop, so it doubles as the consumer's record register.
module lpc_fifo #(
  parameter int WIDTH = 72,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic             full,
  output logic             empty,
  output logic [WIDTH-1:0] rd_data
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [AW:0]      count;
  logic             do_push;
  logic             do_pop;

  assign full    = (count == (AW+1)'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + (AW+1)'(1);
        2'b01:   count <= count - (AW+1)'(1);
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
    if (do_pop)  rd_data     <= mem[rd_ptr];
  end

endmodule

// File: rtl/lpc_packer.sv
// Buffers decoded LPC transactions and serialises each into a framed,
// XOR-checksummed byte stream; overflowing records are counted and flagged.
module lpc_packer
  import lpc_packer_pkg::*;
#(
  parameter int         DEPTH     = 4,
  parameter logic [7:0] SYNC_BYTE = SYNC_BYTE_DEFAULT
) (
  input  logic        lpc_clock,
  input  logic        lpc_reset,
  input  logic        in_valid,
  input  logic [3:0]  in_cyctype_dir,
  input  logic [31:0] in_addr,
  input  logic [31:0] in_data,
  input  logic [2:0]  in_data_size,
  output logic [7:0]  out_byte,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [7:0]  drop_count,
  output logic        overflow
);

  function automatic logic [2:0] clamp_size(input logic [2:0] s);
    return (s > 3'(MAX_DATA_BYTES)) ? 3'(MAX_DATA_BYTES) : s;
  endfunction

  function automatic logic [7:0] sat_inc(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

  function automatic logic [7:0] byte_of(input logic [31:0] w, input logic [1:0] i);
    return w[{i, 3'b000} +: 8];
  endfunction

  logic             fifo_full;
  logic             fifo_empty;
  logic             fifo_pop;
  logic             fifo_push;
  logic [REC_W-1:0] push_rec;
  logic [REC_W-1:0] rec;
  logic             pend_loss;
  logic             rec_pending;

  pkt_state_e state, state_nxt;
  logic [1:0] addr_cnt, addr_cnt_nxt;
  logic [1:0] data_cnt, data_cnt_nxt;
  logic [7:0] csum;
  logic [7:0] byte_nxt;
  logic       load_byte;
  logic       csum_en;
  logic       clr_csum;
  logic       fire;

  logic        rec_lost;
  logic [3:0]  rec_ct;
  logic [31:0] rec_addr;
  logic [31:0] rec_data;
  logic [2:0]  rec_size;
  logic [7:0]  hdr;

  // Capture stage: drop decision uses pre-pop occupancy
  assign fifo_push = in_valid & ~fifo_full;
  assign push_rec  = {pend_loss, in_cyctype_dir, in_addr, in_data, clamp_size(in_data_size)};

  always_ff @(posedge lpc_clock) begin
    if (lpc_reset) begin
      drop_count <= '0;
      overflow   <= 1'b0;
      pend_loss  <= 1'b0;
    end else if (in_valid) begin
      if (fifo_full) begin
        drop_count <= sat_inc(drop_count);
        overflow   <= 1'b1;
        pend_loss  <= 1'b1;
      end else begin
        pend_loss  <= 1'b0;
      end
    end
  end

  lpc_fifo #(
    .WIDTH (REC_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk       (lpc_clock),
    .rst       (lpc_reset),
    .push      (fifo_push),
    .push_data (push_rec),
    .pop       (fifo_pop),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .rd_data   (rec)
  );

  assign rec_lost = rec[REC_LOST_BIT];
  assign rec_ct   = rec[REC_CT_LSB +: REC_CT_W];
  assign rec_addr = rec[REC_ADDR_LSB +: REC_ADDR_W];
  assign rec_data = rec[REC_DATA_LSB +: REC_DATA_W];
  assign rec_size = rec[REC_SIZE_LSB +: REC_SIZE_W];
  assign hdr      = {rec_ct, rec_lost, rec_size};

  assign out_valid = (state != ST_IDLE);
  assign fire      = out_valid & out_ready;

  // Framing stage: the next record is prefetched as CSUM is accepted so
  // consecutive frames are separated by a single IDLE cycle.
  always_comb begin
    state_nxt    = state;
    byte_nxt     = out_byte;
    addr_cnt_nxt = addr_cnt;
    data_cnt_nxt = data_cnt;
    load_byte    = 1'b0;
    csum_en      = 1'b0;
    clr_csum     = 1'b0;
    fifo_pop     = 1'b0;
    case (state)
      ST_IDLE: begin
        if (rec_pending) begin
          state_nxt = ST_SYNC;
          byte_nxt  = SYNC_BYTE;
          load_byte = 1'b1;
          clr_csum  = 1'b1;
        end else if (!fifo_empty) begin
          fifo_pop  = 1'b1;
        end
      end
      ST_SYNC: begin
        if (fire) begin
          state_nxt = ST_HEADER;
          byte_nxt  = hdr;
          load_byte = 1'b1;
          csum_en   = 1'b1;
        end
      end
      ST_HEADER: begin
        if (fire) begin
          state_nxt    = ST_ADDR;
          byte_nxt     = byte_of(rec_addr, 2'd3);
          addr_cnt_nxt = 2'd3;
          load_byte    = 1'b1;
          csum_en      = 1'b1;
        end
      end
      ST_ADDR: begin
        if (fire) begin
          load_byte = 1'b1;
          if (addr_cnt != 2'd0) begin
            byte_nxt     = byte_of(rec_addr, addr_cnt - 2'd1);
            addr_cnt_nxt = addr_cnt - 2'd1;
            csum_en      = 1'b1;
          end else if (rec_size != 3'd0) begin
            state_nxt    = ST_DATA;
            byte_nxt     = byte_of(rec_data, 2'd0);
            data_cnt_nxt = 2'd0;
            csum_en      = 1'b1;
          end else begin
            state_nxt    = ST_CSUM;
            byte_nxt     = csum;
          end
        end
      end
      ST_DATA: begin
        if (fire) begin
          load_byte = 1'b1;
          if (({1'b0, data_cnt} + 3'd1) < rec_size) begin
            byte_nxt     = byte_of(rec_data, data_cnt + 2'd1);
            data_cnt_nxt = data_cnt + 2'd1;
            csum_en      = 1'b1;
          end else begin
            state_nxt    = ST_CSUM;
            byte_nxt     = csum;
          end
        end
      end
      ST_CSUM: begin
        if (fire) begin
          state_nxt = ST_IDLE;
          fifo_pop  = ~fifo_empty;
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge lpc_clock) begin
    if (lpc_reset) begin
      state       <= ST_IDLE;
      out_byte    <= 8'h00;
      rec_pending <= 1'b0;
    end else begin
      state <= state_nxt;
      if (load_byte) out_byte <= byte_nxt;
      if (fifo_pop) begin
        rec_pending <= 1'b1;
      end else if (state == ST_IDLE && rec_pending) begin
        rec_pending <= 1'b0;
      end
    end
  end

  always_ff @(posedge lpc_clock) begin
    addr_cnt <= addr_cnt_nxt;
    data_cnt <= data_cnt_nxt;
    if (clr_csum) begin
      csum <= 8'h00;
    end else if (csum_en) begin
      csum <= csum ^ byte_nxt;
    end
  end

endmodule

// File: tb/tb_lpc_packer.sv
// Directed bench for lpc_packer: latency, framing, backpressure, overflow,
// size clamping and mid-frame reset.
module tb_lpc_packer;
  import lpc_packer_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic [3:0]  in_ct;
  logic [31:0] in_addr;
  logic [31:0] in_data;
  logic [2:0]  in_size;
  logic [7:0]  out_byte;
  logic        out_valid;
  logic        out_ready;
  logic [7:0]  drop_count;
  logic        overflow;

  int checks = 0;
  int errors = 0;

  lpc_packer #(.DEPTH(4), .SYNC_BYTE(8'hA5)) dut (
    .lpc_clock      (clk),
    .lpc_reset      (rst),
    .in_valid       (in_valid),
    .in_cyctype_dir (in_ct),
    .in_addr        (in_addr),
    .in_data        (in_data),
    .in_data_size   (in_size),
    .out_byte       (out_byte),
    .out_valid      (out_valid),
    .out_ready      (out_ready),
    .drop_count     (drop_count),
    .overflow       (overflow)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic set_rec(input logic v, input logic [3:0] ct, input logic [31:0] a,
                         input logic [31:0] d, input logic [2:0] s);
    in_valid = v;
    in_ct    = ct;
    in_addr  = a;
    in_data  = d;
    in_size  = s;
  endtask

  task automatic recv_frame(input string tag, input logic [7:0] exp [0:10],
                            input int len, input bit rnd);
    int          got;
    int          cyc;
    logic        stalled;
    logic [7:0]  held;
    got = 0;
    cyc = 0;
    while (got < len && cyc < 300) begin
      out_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      stalled   = out_valid & ~out_ready;
      held      = out_byte;
      if (out_valid && out_ready) begin
        chk($sformatf("%s byte%0d", tag, got), 32'(out_byte), 32'(exp[got]));
        got++;
      end
      tick();
      if (stalled) chk($sformatf("%s hold", tag), 32'(out_byte), 32'(held));
      cyc++;
    end
    out_ready = 1'b1;
    if (got < len) chk($sformatf("%s timeout", tag), 32'(got), 32'(len));
  endtask

  logic [7:0] f_wr32 [0:10];
  logic [7:0] f_rd16 [0:10];
  logic [7:0] f_sz0  [0:10];
  logic [7:0] f_zero [0:10];
  logic [7:0] f_lost [0:10];
  logic [7:0] f_clmp [0:10];

  initial begin
    f_wr32 = '{8'hA5, 8'h64, 8'h12, 8'h34, 8'h7F, 8'hE0, 8'hCD, 8'h69, 8'h00, 8'h00, 8'h79};
    f_rd16 = '{8'hA5, 8'h42, 8'h12, 8'h34, 8'h7F, 8'hE4, 8'hCE, 8'h69, 8'h58, 8'h00, 8'h00};
    f_sz0  = '{8'hA5, 8'h00, 8'h01, 8'h02, 8'h03, 8'h04, 8'h04, 8'h00, 8'h00, 8'h00, 8'h00};
    f_zero = '{8'hA5, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
    f_lost = '{8'hA5, 8'h08, 8'h00, 8'h00, 8'h00, 8'h00, 8'h08, 8'h00, 8'h00, 8'h00, 8'h00};
    f_clmp = '{8'hA5, 8'h24, 8'h00, 8'h00, 8'h00, 8'hF0, 8'h11, 8'h22, 8'h33, 8'h44, 8'h90};

    rst       = 1'b1;
    out_ready = 1'b1;
    set_rec(1'b0, 4'h0, 32'h0, 32'h0, 3'd0);
    tick();
    tick();
    chk("reset out_valid", 32'(out_valid), 32'd0);
    chk("reset out_byte", 32'(out_byte), 32'd0);
    chk("reset drop_count", 32'(drop_count), 32'd0);
    chk("reset overflow", 32'(overflow), 32'd0);
    rst = 1'b0;
    tick();

    // 32-bit mem write, then 16-bit mem read queued one cycle later
    set_rec(1'b1, CT_MEM_WRITE, 32'h12347FE0, 32'h000069CD, 3'd4);
    tick();
    set_rec(1'b1, CT_MEM_READ, 32'h12347FE4, 32'h000069CE, 3'd2);
    chk("lat N out_valid", 32'(out_valid), 32'd0);
    tick();
    in_valid = 1'b0;
    chk("lat N+1 out_valid", 32'(out_valid), 32'd0);
    tick();
    chk("lat N+2 out_valid", 32'(out_valid), 32'd1);
    chk("lat N+2 sync", 32'(out_byte), 32'hA5);
    recv_frame("wr32", f_wr32, 11, 1'b0);
    chk("gap idle", 32'(out_valid), 32'd0);
    tick();
    chk("gap next valid", 32'(out_valid), 32'd1);
    chk("gap next sync", 32'(out_byte), 32'hA5);
    recv_frame("rd16 bp", f_rd16, 9, 1'b1);

    // Overflow: hold a zero-size frame at SYNC, then push six records
    out_ready = 1'b0;
    set_rec(1'b1, CT_IO_READ, 32'h01020304, 32'hFFFFFFFF, 3'd0);
    tick();
    in_valid = 1'b0;
    tick();
    tick();
    chk("stall valid", 32'(out_valid), 32'd1);
    chk("stall sync", 32'(out_byte), 32'hA5);
    set_rec(1'b1, CT_IO_READ, 32'h0, 32'h0, 3'd0);
    repeat (6) tick();
    in_valid = 1'b0;
    chk("ovf drop_count", 32'(drop_count), 32'd2);
    chk("ovf flag", 32'(overflow), 32'd1);
    recv_frame("size0", f_sz0, 7, 1'b0);
    recv_frame("buf A", f_zero, 7, 1'b0);
    set_rec(1'b1, CT_IO_READ, 32'h0, 32'h0, 3'd0);
    tick();
    in_valid = 1'b0;
    recv_frame("buf B", f_zero, 7, 1'b0);
    recv_frame("buf C", f_zero, 7, 1'b0);
    recv_frame("buf D", f_zero, 7, 1'b0);
    recv_frame("lost rec", f_lost, 7, 1'b0);
    chk("ovf drop_count hold", 32'(drop_count), 32'd2);

    // Size above four is clamped
    set_rec(1'b1, CT_IO_WRITE, 32'h000000F0, 32'h44332211, 3'd7);
    tick();
    in_valid = 1'b0;
    recv_frame("clamp", f_clmp, 11, 1'b0);

    // Reset after the third byte is accepted, with a second record buffered
    set_rec(1'b1, CT_MEM_WRITE, 32'h12347FE0, 32'h000069CD, 3'd4);
    tick();
    set_rec(1'b1, CT_MEM_READ, 32'h12347FE4, 32'h000069CE, 3'd2);
    tick();
    in_valid = 1'b0;
    for (int i = 0; i < 10 && !out_valid; i++) tick();
    chk("rst frame start", 32'(out_byte), 32'hA5);
    repeat (3) tick();
    chk("rst pre 4th byte", 32'(out_byte), 32'h34);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("rst out_valid", 32'(out_valid), 32'd0);
    chk("rst out_byte", 32'(out_byte), 32'd0);
    chk("rst drop_count", 32'(drop_count), 32'd0);
    chk("rst overflow", 32'(overflow), 32'd0);
    for (int i = 0; i < 6; i++) begin
      tick();
      chk($sformatf("rst quiet %0d", i), 32'(out_valid), 32'd0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

endmodule
